wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter for the integer core: the producer side of the register-file write port (Rw_en/Rw_addr/Rw).
- Accepts completed results from two sources over valid/ready handshakes:
  - ALU/branch path.
  - Long-latency path (LSU load data, MUL/DIV).
- Selects one result per cycle and registers it onto the single register-file write port.
- Maintains a starvation guard and a retire counter for difftest.

Parameters:
- XLEN, 64, data width of results and of the Rw port
- REG_AW, 5, register address width (32 architectural registers)
- STARVE_LIMIT, 4, consecutive cycles the long-latency source may be refused before it is granted priority
- CNT_W, 64, width of the retire counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  REG_AW  ALU destination register
- alu_wen  in  1  ALU instruction writes rd (0 = retire-only, e.g. store/branch)
- alu_data  in  XLEN  ALU result
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  long-latency result accepted this cycle
- ll_rd  in  REG_AW  long-latency destination register
- ll_wen  in  1  long-latency instruction writes rd
- ll_data  in  XLEN  long-latency result
- Rw_en  out  1  register-file write enable
- Rw_addr  out  REG_AW  register-file write address
- Rw  out  XLEN  register-file write data
- retire_valid  out  1  one instruction retired (registered, aligned with Rw_en)
- retire_cnt  out  CNT_W  total retired instructions

Behaviour:
- Reset (async assert, sync release): all outputs 0 (Rw_en, Rw_addr, Rw, retire_valid, retire_cnt); starve_cnt = 0; prio_ll = 0.
- Ready signals are combinational from the registered state and the two valid inputs:
  - Default (prio_ll=0): alu_ready = 1; ll_ready = !alu_valid.
  - prio_ll=1: ll_ready = 1; alu_ready = !ll_valid.
  - Both ready outputs are 0 while rst_n = 0.
- Grant:
  - A transfer occurs on the edge where valid && ready for that source.
  - At most one transfer per cycle; the two grants are mutually exclusive by construction.
- Output register, 1-cycle latency from the accepting edge:
  - Rw_addr = rd and Rw = data of the granted source.
  - Rw_en = wen && (rd != 0). Writes to x0 are never issued, although Rw_addr/Rw still update.
  - retire_valid = 1 for any granted transfer, including wen=0 and rd=0.
  - No grant: Rw_en = 0 and retire_valid = 0. Rw_addr and Rw hold their last values.
- retire_cnt: increments by 1 on each grant, wraps modulo 2^CNT_W.
- Starvation guard:
  - starve_cnt increments when ll_valid && !ll_ready; clears on any ll grant or when ll_valid = 0.
  - When starve_cnt reaches STARVE_LIMIT-1 and ll is still refused, set prio_ll = 1 for the next cycle.
  - prio_ll clears after the ll grant, or when ll_valid drops.
  - Saturating; never wraps.
- Sources must hold valid and payload stable until accepted. The block registers nothing from a source until its grant.
- Reset mid-operation: any pending result is dropped and the next cycle shows Rw_en = 0. Sources re-present after reset.
- No internal storage beyond the output stage; throughput is one result per cycle.

Decomposition:
- Shared package/defines: XLEN, REG_AW, ZERO_64 and the data/register bus macros, already used by the register file.
- One sub-module: wb_starve_guard, containing starve_cnt, prio_ll and the ready computation. It outputs alu_ready and ll_ready.
- Grant mux, output register and retire counter stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high -> both readys 0, Rw_en=0, retire_cnt=0. Release -> normal grants resume on the next edge.
- ALU only: alu_valid=1, alu_rd=5, alu_wen=1, alu_data=0x1234 for 1 cycle -> next cycle Rw_en=1, Rw_addr=5, Rw=0x1234, retire_valid=1, retire_cnt=1.
- x0 suppression: ALU rd=0, wen=1, data=0xFFFF -> Rw_en=0, retire_valid=1, retire_cnt increments.
- Collision: both valid, alu rd=3 data=0xA, ll rd=7 data=0xB, ALU then idle -> cycle 1 writes x3=0xA, cycle 2 writes x7=0xB; ll_ready=0 during cycle 0.
- Starvation: alu_valid and ll_valid held high continuously -> ll refused for exactly STARVE_LIMIT=4 cycles, then ll_ready=1 and alu_ready=0 for one grant. Pattern repeats: 4 ALU grants, 1 LL grant.
- Retire-only: ll_wen=0, ll_rd=9 -> Rw_en=0, retire_valid=1. Preset retire_cnt to all-ones via forced state, then one grant -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: datapath widths, the zero constant used by
// the register file, bus typedefs and the arbitration priority encoding.
package wb_arbiter_pkg;

   localparam int XLEN             = 64;
   localparam int REG_AW           = 5;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int CNT_W_DEF        = 64;

   localparam logic [63:0] ZERO_64 = 64'h0;

   typedef logic [XLEN-1:0]   data_t;
   typedef logic [REG_AW-1:0] regAddr_t;

   // Which source wins a collision this cycle.
   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_LL  = 1'b1
   } prio_e;

endpackage

// File: rtl/wb_starve_guard.sv
// Starvation guard for the write-back arbiter. Normally the ALU path wins a
// collision; once the long-latency source has been refused STARVE_LIMIT
// cycles in a row it is given priority until it gets its grant.
module wb_starve_guard #(
   parameter int STARVE_LIMIT = wb_arbiter_pkg::STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic alu_valid,
   input  logic ll_valid,
   output logic alu_ready,
   output logic ll_ready
);
   import wb_arbiter_pkg::*;

   localparam int            CW   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(STARVE_LIMIT - 1);

   prio_e         prioLl_q, prioLl_d;
   logic [CW-1:0] starveCnt_q, starveCnt_d;
   logic          llGrant;

   // Ready outputs come only from registered priority and the two valids,
   // and are forced low while the core is held in reset.
   always_comb begin
      alu_ready = 1'b0;
      ll_ready  = 1'b0;
      if (rst_n) begin
         if (prioLl_q == PRIO_LL) begin
            ll_ready  = 1'b1;
            alu_ready = !ll_valid;
         end else begin
            alu_ready = 1'b1;
            ll_ready  = !alu_valid;
         end
      end
   end

   assign llGrant = ll_valid && ll_ready;

   // Count consecutive refusals of a waiting long-latency result; the refusal
   // seen at the last count value flips priority for the following cycle.
   always_comb begin
      starveCnt_d = starveCnt_q;
      prioLl_d    = prioLl_q;
      if (!ll_valid || llGrant) begin
         starveCnt_d = '0;
         prioLl_d    = PRIO_ALU;
      end else if (starveCnt_q == LAST) begin
         prioLl_d = PRIO_LL;
      end else begin
         starveCnt_d = starveCnt_q + 1'b1;
      end
   end

   // Guard state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starveCnt_q <= '0;
         prioLl_q    <= PRIO_ALU;
      end else begin
         starveCnt_q <= starveCnt_d;
         prioLl_q    <= prioLl_d;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one of the ALU or long-latency results per cycle
// and registers it onto the register-file write port, while counting every
// retired instruction for difftest.
module wb_arbiter #(
   parameter int XLEN         = wb_arbiter_pkg::XLEN,
   parameter int REG_AW       = wb_arbiter_pkg::REG_AW,
   parameter int STARVE_LIMIT = wb_arbiter_pkg::STARVE_LIMIT_DEF,
   parameter int CNT_W        = wb_arbiter_pkg::CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic              alu_wen,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ll_valid,
   output logic              ll_ready,
   input  logic [REG_AW-1:0] ll_rd,
   input  logic              ll_wen,
   input  logic [XLEN-1:0]   ll_data,
   output logic              Rw_en,
   output logic [REG_AW-1:0] Rw_addr,
   output logic [XLEN-1:0]   Rw,
   output logic              retire_valid,
   output logic [CNT_W-1:0]  retire_cnt
);
   import wb_arbiter_pkg::*;

   logic              aluGrant, llGrant;
   logic              rwEn_q, rwEn_d;
   logic [REG_AW-1:0] rwAddr_q, rwAddr_d;
   logic [XLEN-1:0]   rw_q, rw_d;
   logic              retireValid_q, retireValid_d;
   logic [CNT_W-1:0]  retireCnt_q, retireCnt_d;

   wb_starve_guard #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) uGuard (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .ll_valid  (ll_valid),
      .alu_ready (alu_ready),
      .ll_ready  (ll_ready)
   );

   // The guard never raises both readys against two valids, so at most one
   // of these grants is set in any cycle.
   assign aluGrant = alu_valid && alu_ready;
   assign llGrant  = ll_valid && ll_ready;

   // Next output stage: strobes drop when idle while address/data hold, and
   // x0 destinations still retire but never raise the write enable.
   always_comb begin
      rwEn_d        = 1'b0;
      retireValid_d = 1'b0;
      rwAddr_d      = rwAddr_q;
      rw_d          = rw_q;
      retireCnt_d   = retireCnt_q;
      if (aluGrant) begin
         rwAddr_d      = alu_rd;
         rw_d          = alu_data;
         rwEn_d        = alu_wen && (alu_rd != '0);
         retireValid_d = 1'b1;
      end else if (llGrant) begin
         rwAddr_d      = ll_rd;
         rw_d          = ll_data;
         rwEn_d        = ll_wen && (ll_rd != '0);
         retireValid_d = 1'b1;
      end
      if (aluGrant || llGrant) begin
         retireCnt_d = retireCnt_q + 1'b1;
      end
   end

   // Output register and retire counter; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rwEn_q        <= 1'b0;
         rwAddr_q      <= '0;
         rw_q          <= XLEN'(ZERO_64);
         retireValid_q <= 1'b0;
         retireCnt_q   <= '0;
      end else begin
         rwEn_q        <= rwEn_d;
         rwAddr_q      <= rwAddr_d;
         rw_q          <= rw_d;
         retireValid_q <= retireValid_d;
         retireCnt_q   <= retireCnt_d;
      end
   end

   assign Rw_en        = rwEn_q;
   assign Rw_addr      = rwAddr_q;
   assign Rw           = rw_q;
   assign retire_valid = retireValid_q;
   assign retire_cnt   = retireCnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with literal expectations,
// then protocol-respecting random traffic checked every cycle against a
// behavioural model of the arbitration rules.
module tb_wb_arbiter;

   localparam int XLEN         = 64;
   localparam int REG_AW       = 5;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 8;

   logic              clk;
   logic              rst_n;
   logic              alu_valid, alu_ready, alu_wen;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              ll_valid, ll_ready, ll_wen;
   logic [REG_AW-1:0] ll_rd;
   logic [XLEN-1:0]   ll_data;
   logic              Rw_en, retire_valid;
   logic [REG_AW-1:0] Rw_addr;
   logic [XLEN-1:0]   Rw;
   logic [CNT_W-1:0]  retire_cnt;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(
      .XLEN         (XLEN),
      .REG_AW       (REG_AW),
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_wen      (alu_wen),
      .alu_data     (alu_data),
      .ll_valid     (ll_valid),
      .ll_ready     (ll_ready),
      .ll_rd        (ll_rd),
      .ll_wen       (ll_wen),
      .ll_data      (ll_data),
      .Rw_en        (Rw_en),
      .Rw_addr      (Rw_addr),
      .Rw           (Rw),
      .retire_valid (retire_valid),
      .retire_cnt   (retire_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, and report it when it disagrees.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive a full input set just after a rising edge, then wait for the
   // following falling edge so the caller can sample.
   task automatic applyStimulus(input logic rstN,
                                input logic av, input logic [4:0] ard, input logic awen, input logic [63:0] adata,
                                input logic lv, input logic [4:0] lrd, input logic lwen, input logic [63:0] ldata);
      @(posedge clk);
      #1;
      rst_n     = rstN;
      alu_valid = av;  alu_rd = ard; alu_wen = awen; alu_data = adata;
      ll_valid  = lv;  ll_rd  = lrd; ll_wen  = lwen; ll_data  = ldata;
      @(negedge clk);
   endtask

   function automatic logic [4:0] randRd();
      if ($urandom_range(0, 7) == 0) return 5'd0;
      return 5'($urandom_range(1, 31));
   endfunction

   // Behavioural model: the long-latency source gains priority once it has
   // been turned away STARVE_LIMIT cycles running; the result accepted at an
   // edge shows on the write port after that edge.
   int               mRefused = 0;
   logic             expRwEn = 1'b0, expRet = 1'b0;
   logic [4:0]       expAddr = '0;
   logic [63:0]      expRw = '0;
   logic [CNT_W-1:0] expCnt = '0;

   always @(negedge clk) begin
      logic mPrio, expAluR, expLlR, aluGo, llGo;
      if (!rst_n) begin
         mRefused = 0;
         expRwEn  = 1'b0; expRet = 1'b0; expAddr = '0; expRw = '0; expCnt = '0;
         checkOutput("rst_alu_ready", 64'(alu_ready), 64'(1'b0));
         checkOutput("rst_ll_ready",  64'(ll_ready),  64'(1'b0));
      end else begin
         mPrio   = (mRefused >= STARVE_LIMIT);
         expAluR = mPrio ? !ll_valid : 1'b1;
         expLlR  = mPrio ? 1'b1 : !alu_valid;
         checkOutput("alu_ready", 64'(alu_ready), 64'(expAluR));
         checkOutput("ll_ready",  64'(ll_ready),  64'(expLlR));
      end
      checkOutput("Rw_en",        64'(Rw_en),        64'(expRwEn));
      checkOutput("Rw_addr",      64'(Rw_addr),      64'(expAddr));
      checkOutput("Rw",           Rw,                expRw);
      checkOutput("retire_valid", 64'(retire_valid), 64'(expRet));
      checkOutput("retire_cnt",   64'(retire_cnt),   64'(expCnt));
      if (rst_n) begin
         aluGo = alu_valid && expAluR;
         llGo  = ll_valid && expLlR;
         expRwEn = 1'b0;
         expRet  = 1'b0;
         if (aluGo) begin
            expAddr = alu_rd; expRw = alu_data;
            expRwEn = alu_wen && (alu_rd != 5'd0);
            expRet  = 1'b1; expCnt = expCnt + 1'b1;
         end else if (llGo) begin
            expAddr = ll_rd; expRw = ll_data;
            expRwEn = ll_wen && (ll_rd != 5'd0);
            expRet  = 1'b1; expCnt = expCnt + 1'b1;
         end
         if (ll_valid && !llGo) mRefused++;
         else mRefused = 0;
      end
   end

   int pAluTab [6] = '{90, 50, 100, 20, 100, 70};
   int pLlTab  [6] = '{90, 50, 30, 100, 100, 20};

   // Directed scenarios followed by random traffic.
   initial begin
      logic aluTook, llTook;
      int   rstLeft;
      int   pA, pL;
      logic llR;

      rst_n = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_wen = 1'b0; alu_data = '0;
      ll_valid  = 1'b0; ll_rd  = '0; ll_wen  = 1'b0; ll_data  = '0;
      #1;
      rst_n = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_wen = 1'b1; alu_data = 64'h55;
      ll_valid  = 1'b1; ll_rd  = 5'd4; ll_wen  = 1'b1; ll_data  = 64'h66;
      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] reset held with both sources valid");
      checkOutput("lit_rst_alu_ready", 64'(alu_ready), 64'd0);
      checkOutput("lit_rst_ll_ready",  64'(ll_ready),  64'd0);
      checkOutput("lit_rst_Rw_en",     64'(Rw_en),     64'd0);
      checkOutput("lit_rst_cnt",       64'(retire_cnt), 64'd0);

      $display("[TB] ALU only after reset release");
      applyStimulus(1, 1, 5'd5, 1, 64'h1234, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_alu_ready", 64'(alu_ready), 64'd1);
      checkOutput("lit_ll_ready",  64'(ll_ready),  64'd0);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_alu_Rw_en",  64'(Rw_en),        64'd1);
      checkOutput("lit_alu_addr",   64'(Rw_addr),      64'd5);
      checkOutput("lit_alu_Rw",     Rw,                64'h1234);
      checkOutput("lit_alu_retire", 64'(retire_valid), 64'd1);
      checkOutput("lit_alu_cnt",    64'(retire_cnt),   64'd1);

      $display("[TB] x0 suppression");
      applyStimulus(1, 1, 5'd0, 1, 64'hFFFF, 0, 5'd0, 0, 64'h0);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_x0_Rw_en",  64'(Rw_en),        64'd0);
      checkOutput("lit_x0_retire", 64'(retire_valid), 64'd1);
      checkOutput("lit_x0_Rw",     Rw,                64'hFFFF);
      checkOutput("lit_x0_cnt",    64'(retire_cnt),   64'd2);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_idle_retire", 64'(retire_valid), 64'd0);
      checkOutput("lit_idle_Rw_hold", Rw,               64'hFFFF);
      checkOutput("lit_idle_cnt",    64'(retire_cnt),   64'd2);

      $display("[TB] collision");
      applyStimulus(1, 1, 5'd3, 1, 64'hA, 1, 5'd7, 1, 64'hB);
      checkOutput("lit_col_ll_ready",  64'(ll_ready),  64'd0);
      checkOutput("lit_col_alu_ready", 64'(alu_ready), 64'd1);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 1, 5'd7, 1, 64'hB);
      checkOutput("lit_col_addr1", 64'(Rw_addr), 64'd3);
      checkOutput("lit_col_Rw1",   Rw,           64'hA);
      checkOutput("lit_col_ll_ready2", 64'(ll_ready), 64'd1);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_col_addr2", 64'(Rw_addr), 64'd7);
      checkOutput("lit_col_Rw2",   Rw,           64'hB);
      checkOutput("lit_col_cnt",   64'(retire_cnt), 64'd4);

      $display("[TB] starvation with both sources saturated");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1, 1, 5'd12, 1, 64'hC, 1, 5'd9, 0, 64'h99);
         llR = ((k % 5) == 4);
         checkOutput($sformatf("lit_starve_ll_ready_%0d", k),  64'(ll_ready),  64'(llR));
         checkOutput($sformatf("lit_starve_alu_ready_%0d", k), 64'(alu_ready), 64'(!llR));
         if (k == 5) begin
            checkOutput("lit_ret_only_addr",   64'(Rw_addr),      64'd9);
            checkOutput("lit_ret_only_Rw_en",  64'(Rw_en),        64'd0);
            checkOutput("lit_ret_only_retire", 64'(retire_valid), 64'd1);
         end
      end
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_starve_addr", 64'(Rw_addr),    64'd9);
      checkOutput("lit_starve_cnt",  64'(retire_cnt), 64'd14);

      $display("[TB] retire counter wrap");
      for (int i = 0; i < 241; i++) begin
         applyStimulus(1, 1, 5'd1, 1, 64'(i), 0, 5'd0, 0, 64'h0);
      end
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 1, 5'd9, 0, 64'h77);
      checkOutput("lit_wrap_cnt_max", 64'(retire_cnt), 64'd255);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_wrap_cnt_zero", 64'(retire_cnt),   64'd0);
      checkOutput("lit_wrap_Rw_en",    64'(Rw_en),        64'd0);
      checkOutput("lit_wrap_retire",   64'(retire_valid), 64'd1);

      $display("[TB] reset mid-operation");
      applyStimulus(1, 1, 5'd6, 1, 64'hDEAD, 1, 5'd8, 1, 64'hBEEF);
      applyStimulus(0, 1, 5'd6, 1, 64'hDEAD, 1, 5'd8, 1, 64'hBEEF);
      checkOutput("lit_midrst_Rw_en", 64'(Rw_en),      64'd0);
      checkOutput("lit_midrst_cnt",   64'(retire_cnt), 64'd0);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      checkOutput("lit_midrst_retire", 64'(retire_valid), 64'd0);

      $display("[TB] random traffic");
      rstLeft = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         aluTook = alu_valid && alu_ready;
         llTook  = ll_valid && ll_ready;
         @(posedge clk);
         #1;
         if (rstLeft > 0) begin
            rst_n = 1'b0;
            rstLeft--;
         end else begin
            rst_n = 1'b1;
            if ($urandom_range(0, 249) == 0) begin
               rst_n   = 1'b0;
               rstLeft = int'($urandom_range(0, 2));
            end
         end
         pA = pAluTab[i / 500];
         pL = pLlTab[i / 500];
         if (!(alu_valid && !aluTook)) begin
            if (int'($urandom_range(0, 99)) < pA) begin
               alu_valid = 1'b1;
               alu_rd    = randRd();
               alu_wen   = ($urandom_range(0, 3) != 0);
               alu_data  = {$urandom(), $urandom()};
            end else begin
               alu_valid = 1'b0;
            end
         end
         if (!(ll_valid && !llTook)) begin
            if (int'($urandom_range(0, 99)) < pL) begin
               ll_valid = 1'b1;
               ll_rd    = randRd();
               ll_wen   = ($urandom_range(0, 3) != 0);
               ll_data  = {$urandom(), $urandom()};
            end else begin
               ll_valid = 1'b0;
            end
         end
      end

      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      applyStimulus(1, 0, 5'd0, 0, 64'h0, 0, 5'd0, 0, 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
